// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  // Index width for a channel count (at least one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a rotating priority pointer.
module rr_arbiter import rr_arb_mux_pkg::*; #(
  parameter int unsigned nreqs = 4,
  localparam int unsigned pw = sel_width(nreqs)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [nreqs-1:0] req,
  input  logic             en,
  output logic [nreqs-1:0] grant
);

  logic [pw-1:0] ptr;
  logic [pw-1:0] ptr_nxt;

  // First requester at or after ptr wins; the pointer moves past the winner.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant   = '0;
    ptr_nxt = ptr;
    for (int unsigned k = 0; k < nreqs; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= nreqs) idx = idx - nreqs;
      if (grant == '0 && req[pw'(idx)]) begin
        grant[pw'(idx)] = 1'b1;
        ptr_nxt         = (idx + 1 >= nreqs) ? '0 : pw'(idx + 1);
      end
    end
  end

  // Priority only rotates on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && (grant != '0)) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbitrating mux with a one-entry registered output stage.
module rr_arb_mux import rr_arb_mux_pkg::*; #(
  parameter int unsigned nbits = 4,
  parameter int unsigned nreqs = 4,
  localparam int unsigned selw = sel_width(nreqs)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nreqs-1:0]       in_val,
  output logic [nreqs-1:0]       in_rdy,
  input  logic [nreqs*nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [nbits-1:0]       out_msg,
  output logic [selw-1:0]        out_sel
);

  logic [nreqs-1:0] grant;
  logic             accept_en;
  logic             xfer;
  logic [nbits-1:0] msg_c;
  logic [selw-1:0]  sel_c;

  assign accept_en = !out_val || out_rdy;
  assign in_rdy    = (accept_en && !rst) ? grant : '0;
  assign xfer      = |(in_val & in_rdy);

  rr_arbiter #(.nreqs(nreqs)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (in_val),
    .en    (accept_en && !rst),
    .grant (grant)
  );

  // AND-OR select of the granted slice and its index.
  always_comb begin
    msg_c = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < nreqs; i++) begin
      msg_c = msg_c | (in_msg[i*nbits +: nbits] & {nbits{grant[i]}});
      sel_c = sel_c | (grant[i] ? selw'(i) : '0);
    end
  end

  // Output register: refill on transfer, otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_sel <= '0;
    end else if (xfer) begin
      out_val <= 1'b1;
      out_msg <= msg_c;
      out_sel <= sel_c;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic vs a behavioural model.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_val;
  logic [3:0]  in_rdy;
  logic [15:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [3:0]  out_msg;
  logic [1:0]  out_sel;

  logic        rst3;
  logic [2:0]  in_val3;
  logic [2:0]  in_rdy3;
  logic [11:0] in_msg3;
  logic        out_val3;
  logic        out_rdy3;
  logic [3:0]  out_msg3;
  logic [1:0]  out_sel3;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the 4-channel instance.
  logic       m_val;
  logic [3:0] m_msg;
  int         m_sel;
  int         m_ptr;
  logic [3:0] last_rdy;

  always #5 clk = ~clk;

  rr_arb_mux #(.nbits(4), .nreqs(4)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_sel(out_sel)
  );

  rr_arb_mux #(.nbits(4), .nreqs(3)) dut3 (
    .clk(clk), .rst(rst3), .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
    .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3), .out_sel(out_sel3)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid channel found walking up from ptr, wrapping.
  function automatic logic [3:0] model_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (v[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  // One clock: drive, check ready, advance the model, check the output register.
  task automatic step(input logic [3:0] v, input logic [15:0] m, input logic ordy, input logic r);
    logic [3:0] exp_rdy;
    in_val  = v;
    in_msg  = m;
    out_rdy = ordy;
    rst     = r;
    #2;
    exp_rdy = (!r && (!m_val || ordy)) ? model_grant(v, m_ptr) : 4'b0000;
    last_rdy = exp_rdy;
    chk("in_rdy", int'(in_rdy), int'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_val = 1'b0; m_msg = 4'h0; m_sel = 0; m_ptr = 0;
    end else if (exp_rdy != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_rdy[i]) begin
          m_val = 1'b1;
          m_msg = m[i*4 +: 4];
          m_sel = i;
          m_ptr = (i + 1) % 4;
        end
      end
    end else if (m_val && ordy) begin
      m_val = 1'b0;
    end
    #1;
    chk("out_val", int'(out_val), int'(m_val));
    chk("out_msg", int'(out_msg), int'(m_msg));
    chk("out_sel", int'(out_sel), m_sel);
  endtask

  initial begin
    logic [3:0]  pend;
    logic [15:0] pmsg;
    logic        ordy;
    logic        r;

    m_val = 1'b0; m_msg = 4'h0; m_sel = 0; m_ptr = 0; last_rdy = 4'h0;
    rst = 1'b1; in_val = 4'h0; in_msg = 16'h0; out_rdy = 1'b0;
    rst3 = 1'b1; in_val3 = 3'h0; in_msg3 = 12'h0; out_rdy3 = 1'b0;
    @(posedge clk); #1;

    // Reset with all channels requesting.
    for (int i = 0; i < 2; i++) begin
      step(4'hF, 16'h4321, 1'b1, 1'b1);
      chk("rst_rdy", int'(in_rdy), 0);
      chk("rst_val", int'(out_val), 0);
      chk("rst_msg", int'(out_msg), 0);
      chk("rst_sel", int'(out_sel), 0);
    end
    step(4'hF, 16'h4321, 1'b1, 1'b0);
    chk("first_grant", int'(last_rdy), 1);
    chk("first_sel", int'(out_sel), 0);

    // Single channel 2, then the pointer must sit at 3.
    step(4'b0100, 16'h0A00, 1'b1, 1'b0);
    chk("single_rdy", int'(last_rdy), 4);
    chk("single_msg", int'(out_msg), 4'hA);
    chk("single_sel", int'(out_sel), 2);
    step(4'hF, 16'h4321, 1'b1, 1'b0);
    chk("ptr_after_ch2", int'(last_rdy), 8);

    // Full contention: rotation 0,1,2,3 with no bubbles.
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 16'h4321, 1'b1, 1'b0);
      chk("rot_val", int'(out_val), 1);
      chk("rot_sel", int'(out_sel), i % 4);
      chk("rot_msg", int'(out_msg), (i % 4) + 1);
    end

    // Backpressure holds the register, then refill on the releasing edge.
    step(4'b0001, 16'h0005, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 16'h0070, 1'b0, 1'b0);
      chk("bp_rdy", int'(last_rdy), 0);
      chk("bp_msg", int'(out_msg), 5);
      chk("bp_val", int'(out_val), 1);
    end
    step(4'b0010, 16'h0070, 1'b1, 1'b0);
    chk("bp_release_rdy", int'(last_rdy), 2);
    chk("bp_release_msg", int'(out_msg), 7);

    // Wrap and skip: ch3, then only ch1/ch3 alternate.
    step(4'b1000, 16'h9000, 1'b1, 1'b0);
    chk("wrap_sel3", int'(out_sel), 3);
    step(4'b1010, 16'hC0D0, 1'b1, 1'b0);
    chk("skip_sel_a", int'(out_sel), 1);
    step(4'b1010, 16'hC0D0, 1'b1, 1'b0);
    chk("skip_sel_b", int'(out_sel), 3);
    step(4'b1010, 16'hC0D0, 1'b1, 1'b0);
    chk("skip_sel_c", int'(out_sel), 1);

    // Reset during a stall discards the held message and the pointer.
    step(4'b0001, 16'h000B, 1'b1, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 1'b0);
    chk("stall_msg", int'(out_msg), 4'hB);
    step(4'b0000, 16'h0000, 1'b0, 1'b1);
    chk("midrst_val", int'(out_val), 0);
    chk("midrst_msg", int'(out_msg), 0);
    step(4'hF, 16'h4321, 1'b1, 1'b0);
    chk("midrst_ptr", int'(last_rdy), 1);

    // Randomized traffic; requesters hold until served.
    pend = 4'h0;
    pmsg = 16'h0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          pmsg[i*4 +: 4] = 4'($urandom_range(15, 0));
        end
      end
      ordy = ($urandom_range(3, 0) != 0);
      r    = ($urandom_range(99, 0) == 0);
      step(pend, pmsg, ordy, r);
      pend = pend & ~last_rdy;
    end

    // Three-channel instance: rotation wraps at 2.
    @(posedge clk); #1;
    rst3 = 1'b0; in_val3 = 3'b111; in_msg3 = 12'h321; out_rdy3 = 1'b1;
    #1;
    chk("n3_first_rdy", int'(in_rdy3), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("n3_val", int'(out_val3), 1);
      chk("n3_sel", int'(out_sel3), i % 3);
      chk("n3_msg", int'(out_msg3), (i % 3) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
